// File: rtl/apb_ms_pkg.sv
// Purpose: shared types for the APB multi-slave subsystem (master FSM states, latched request).
// Latency: n/a (types only).
// Backpressure: n/a.
package apb_ms_pkg;

    // Request fields are stored at these ceiling widths. The top narrows them back
    // to its own ADDR_W/DATA_W, so one struct type serves every parameterisation.
    localparam int REQ_ADDR_MAX = 32;
    localparam int REQ_DATA_MAX = 128;
    localparam int REQ_STRB_MAX = REQ_DATA_MAX / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                    write;
        logic [REQ_ADDR_MAX-1:0] addr;
        logic [REQ_DATA_MAX-1:0] wdata;
        logic [REQ_STRB_MAX-1:0] strb;
    } apb_req_t;

endpackage

// File: rtl/apb_regbank_slave.sv
// Purpose: APB slave with a DEPTH x DATA_W register bank and byte-strobed writes.
// Latency: PREADY after WAIT_CYC ACCESS cycles; reads are combinational from the bank.
// Backpressure: holds PREADY low for WAIT_CYC ACCESS cycles; the bus master waits.
// Ports: clk/rst_n, APB slave inputs psel_i/penable_i/pwrite_i/paddr_i/pwdata_i/pstrb_i,
//        outputs prdata_o/pready_o/pslverr_o (never errors).
module apb_regbank_slave #(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 32,
    parameter  int WAIT_CYC = 1,
    localparam int STRB_W   = DATA_W / 8,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [IDX_W-1:0]  paddr_i,
    input  logic [DATA_W-1:0] pwdata_i,
    input  logic [STRB_W-1:0] pstrb_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o
);

    localparam logic [3:0] WAIT_V = 4'(WAIT_CYC);

    logic [3:0]        wait_q, wait_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              access;

    assign access    = psel_i & penable_i;
    assign pready_o  = access && (wait_q == WAIT_V);
    assign prdata_o  = mem_q[paddr_i];
    assign pslverr_o = 1'b0;

    // The counter restarts in SETUP, so each transfer sees exactly WAIT_CYC waits.
    always_comb begin
        wait_d = wait_q;
        if (psel_i && !penable_i) begin
            wait_d = '0;
        end else if (access && !pready_o) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wait_q <= wait_d;
            if (pready_o && pwrite_i) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (pstrb_i[b]) begin
                        mem_q[paddr_i][b*8 +: 8] <= pwdata_i[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/apb_multi_slave_sys.sv
// Purpose: request-port APB master, address decoder, default error slave and NUM_SLV register banks.
// Latency: accept cycle to rsp_valid is 3+WAIT_CYC cycles (3 for unmapped addresses).
// Backpressure: req_ready is high only while idle; one transfer is in flight at a time.
// Ports: clk/rst_n; request req_valid/req_ready/req_write/req_addr/req_wdata/req_strb;
//        response rsp_valid/rsp_rdata/rsp_err (one-cycle pulse); pready mirrors the bus PREADY.
module apb_multi_slave_sys
    import apb_ms_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 32,
    parameter  int ADDR_W   = 8,
    parameter  int NUM_SLV  = 3,
    parameter  int WAIT_CYC = 1,
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_strb,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              pready
);

    localparam int IDX_W = $clog2(DEPTH);

    apb_state_e        state_q, state_d;
    apb_req_t          req_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic                    psel, penable, complete;
    logic [REQ_ADDR_MAX-1:0] sel_full;
    logic [DATA_W-1:0]       bus_rdata;
    logic                    bus_ready, bus_err;
    logic [DATA_W-1:0]       slv_rdata [NUM_SLV];
    logic [NUM_SLV-1:0]      slv_ready, slv_err;
    logic                    unused_req;

    // Upper bits of the ceiling-width request fields are always zero here.
    assign unused_req = ^req_q;

    assign psel     = (state_q != ST_IDLE);
    assign penable  = (state_q == ST_ACCESS);
    assign sel_full = req_q.addr >> IDX_W;
    assign complete = penable & bus_ready;

    // Gated with rst_n so the port reads busy while reset is held.
    assign req_ready = rst_n && (state_q == ST_IDLE);

    for (genvar s = 0; s < NUM_SLV; s++) begin : g_slv
        apb_regbank_slave #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .WAIT_CYC (WAIT_CYC)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .psel_i    (psel && (sel_full == REQ_ADDR_MAX'(s))),
            .penable_i (penable),
            .pwrite_i  (req_q.write),
            .paddr_i   (req_q.addr[IDX_W-1:0]),
            .pwdata_i  (req_q.wdata[DATA_W-1:0]),
            .pstrb_i   (req_q.strb[STRB_W-1:0]),
            .prdata_o  (slv_rdata[s]),
            .pready_o  (slv_ready[s]),
            .pslverr_o (slv_err[s])
        );
    end

    // Default slave answers unmapped selects: ready on the first ACCESS cycle
    // with PSLVERR; a matching bank overrides it.
    always_comb begin
        bus_rdata = '0;
        bus_ready = penable;
        bus_err   = penable;
        for (int s = 0; s < NUM_SLV; s++) begin
            if (sel_full == REQ_ADDR_MAX'(s)) begin
                bus_rdata = slv_rdata[s];
                bus_ready = slv_ready[s];
                bus_err   = slv_err[s];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (bus_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                req_q <= '{write: req_write,
                           addr:  REQ_ADDR_MAX'(req_addr),
                           wdata: REQ_DATA_MAX'(req_wdata),
                           strb:  REQ_STRB_MAX'(req_strb)};
            end
            rsp_valid_q <= complete;
            rsp_rdata_q <= (complete && !req_q.write) ? bus_rdata : '0;
            rsp_err_q   <= complete & bus_err;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign pready    = bus_ready;

endmodule
